// File: rtl/register_file.sv
// Two-read, one-write MIPS register file: combinational reads, synchronous writes, r0 fixed at zero.
// Optional macro REG_FILE_WRITE_BYPASS_EN forwards same-cycle write data to matching read ports.
module register_file #(
    parameter int unsigned REG_NUM    = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic [ADDR_WIDTH-1:0] register_1_read_addr_i,
    input  logic [ADDR_WIDTH-1:0] register_2_read_addr_i,
    input  logic [ADDR_WIDTH-1:0] register_write_addr_i,
    input  logic [DATA_WIDTH-1:0] register_write_data_i,
    input  logic                  register_write_i,
    output logic [DATA_WIDTH-1:0] register_1_data_o,
    output logic [DATA_WIDTH-1:0] register_2_data_o
);

    localparam int unsigned ADDR_EXT_W = ADDR_WIDTH + 1;
    localparam logic [ADDR_EXT_W-1:0] REG_LIMIT = ADDR_EXT_W'(REG_NUM);

    logic [DATA_WIDTH-1:0] inner_registers [0:REG_NUM-1];
    logic                  write_hit;

    // Only nonzero, in-range addresses map to real storage.
    function automatic logic addr_valid(input logic [ADDR_WIDTH-1:0] addr);
        return (addr != '0) && ({1'b0, addr} < REG_LIMIT);
    endfunction

    assign write_hit = register_write_i && !reset_i && addr_valid(register_write_addr_i);

    // Storage: reset clears the whole array without waiting for a clock edge.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            for (int unsigned i = 0; i < REG_NUM; i++) begin
                inner_registers[i] <= '0;
            end
        end else if (write_hit) begin
            inner_registers[register_write_addr_i] <= register_write_data_i;
        end
    end

    always_comb begin
        register_1_data_o = '0;
        if (!reset_i && addr_valid(register_1_read_addr_i)) begin
            register_1_data_o = inner_registers[register_1_read_addr_i];
`ifdef REG_FILE_WRITE_BYPASS_EN
            if (write_hit && (register_1_read_addr_i == register_write_addr_i)) begin
                register_1_data_o = register_write_data_i;
            end
`endif
        end
    end

    always_comb begin
        register_2_data_o = '0;
        if (!reset_i && addr_valid(register_2_read_addr_i)) begin
            register_2_data_o = inner_registers[register_2_read_addr_i];
`ifdef REG_FILE_WRITE_BYPASS_EN
            if (write_hit && (register_2_read_addr_i == register_write_addr_i)) begin
                register_2_data_o = register_write_data_i;
            end
`endif
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: a full 32-entry instance and a 20-entry instance (for out-of-range
// addresses) driven together and compared against array models built from the register-file rules.
module tb_register_file;

    logic        clock_i;
    logic        reset_i;
    logic [4:0]  register_1_read_addr_i;
    logic [4:0]  register_2_read_addr_i;
    logic [4:0]  register_write_addr_i;
    logic [31:0] register_write_data_i;
    logic        register_write_i;
    logic [31:0] full_1_data, full_2_data;
    logic [31:0] small_1_data, small_2_data;

    int tests = 0;
    int fails = 0;

    logic [31:0] model_full  [0:31];
    logic [31:0] model_small [0:31];
    logic [31:0] data_hist   [0:31];

    register_file #(.REG_NUM(32), .ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clock_i                (clock_i),
        .reset_i                (reset_i),
        .register_1_read_addr_i (register_1_read_addr_i),
        .register_2_read_addr_i (register_2_read_addr_i),
        .register_write_addr_i  (register_write_addr_i),
        .register_write_data_i  (register_write_data_i),
        .register_write_i       (register_write_i),
        .register_1_data_o      (full_1_data),
        .register_2_data_o      (full_2_data)
    );

    register_file #(.REG_NUM(20), .ADDR_WIDTH(5), .DATA_WIDTH(32)) dut_small (
        .clock_i                (clock_i),
        .reset_i                (reset_i),
        .register_1_read_addr_i (register_1_read_addr_i),
        .register_2_read_addr_i (register_2_read_addr_i),
        .register_write_addr_i  (register_write_addr_i),
        .register_write_data_i  (register_write_data_i),
        .register_write_i       (register_write_i),
        .register_1_data_o      (small_1_data),
        .register_2_data_o      (small_2_data)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // What a read of 'addr' must return right now, for a file of 'reg_num' entries.
    function automatic logic [31:0] expect_read(input logic [4:0] addr, input int reg_num);
        if (reset_i || addr == 5'd0 || int'(addr) >= reg_num) return 32'h0;
`ifdef REG_FILE_WRITE_BYPASS_EN
        if (register_write_i && addr == register_write_addr_i) return register_write_data_i;
`endif
        return (reg_num == 32) ? model_full[addr] : model_small[addr];
    endfunction

    task automatic clear_models();
        for (int i = 0; i < 32; i++) begin
            model_full[i]  = 32'h0;
            model_small[i] = 32'h0;
        end
    endtask

    task automatic check_ports(input string tag, input logic [4:0] a1, input logic [4:0] a2);
        register_1_read_addr_i = a1;
        register_2_read_addr_i = a2;
        #1;
        check({tag, "_full_p1"},  full_1_data,  expect_read(a1, 32));
        check({tag, "_full_p2"},  full_2_data,  expect_read(a2, 32));
        check({tag, "_small_p1"}, small_1_data, expect_read(a1, 20));
        check({tag, "_small_p2"}, small_2_data, expect_read(a2, 20));
    endtask

    // Let one rising edge pass with the current write inputs and apply it to the models.
    task automatic edge_commit();
        @(posedge clock_i);
        if (register_write_i && !reset_i && register_write_addr_i != 5'd0) begin
            model_full[register_write_addr_i] = register_write_data_i;
            if (register_write_addr_i < 5'd20) model_small[register_write_addr_i] = register_write_data_i;
        end
        #1;
    endtask

    task automatic set_write(input logic we, input logic [4:0] wa, input logic [31:0] wd);
        register_write_i      = we;
        register_write_addr_i = wa;
        register_write_data_i = wd;
    endtask

    initial begin
        logic [31:0] old5;
        logic [31:0] old7;
        logic [4:0]  ra1, ra2;

        clear_models();
        set_write(1'b0, 5'd0, 32'h0);
        register_1_read_addr_i = 5'd0;
        register_2_read_addr_i = 5'd0;
        reset_i = 1'b1;

        // Reset held: every address reads zero on both ports.
        for (int a = 0; a < 32; a++) check_ports("reset_held", 5'(a), 5'(31 - a));
        @(negedge clock_i);
        reset_i = 1'b0;
        for (int a = 0; a < 32; a++) check_ports("after_reset", 5'(a), 5'(a));

        // Fill 1..31 with random data, reading n and n-1 after each write.
        data_hist[0] = 32'h0;
        for (int n = 1; n < 32; n++) begin
            data_hist[n] = $urandom;
            set_write(1'b1, 5'(n), data_hist[n]);
            edge_commit();
            set_write(1'b0, 5'd0, 32'h0);
            check_ports("fill", 5'(n), 5'(n - 1));
            register_1_read_addr_i = 5'(n);
            register_2_read_addr_i = 5'(n - 1);
            #1;
            check("fill_const_p1", full_1_data, data_hist[n]);
            check("fill_const_p2", full_2_data, data_hist[n - 1]);
        end

        // Writes to r0 are discarded.
        set_write(1'b1, 5'd0, 32'hDEADBEEF);
        edge_commit();
        set_write(1'b0, 5'd0, 32'h0);
        register_1_read_addr_i = 5'd0;
        register_2_read_addr_i = 5'd0;
        #1;
        check("zero_reg_p1", full_1_data, 32'h0);
        check("zero_reg_p2", full_2_data, 32'h0);

        // Enable low: address 5 holds.
        old5 = data_hist[5];
        set_write(1'b0, 5'd5, 32'h12345678);
        edge_commit();
        register_1_read_addr_i = 5'd5;
        #1;
        check("enable_low", full_1_data, old5);

        // Same-address read during write of r7.
        old7 = data_hist[7];
        set_write(1'b1, 5'd7, 32'hA5A5A5A5);
        register_1_read_addr_i = 5'd7;
        #1;
`ifdef REG_FILE_WRITE_BYPASS_EN
        check("raw_before_edge", full_1_data, 32'hA5A5A5A5);
`else
        check("raw_before_edge", full_1_data, old7);
`endif
        edge_commit();
        set_write(1'b0, 5'd0, 32'h0);
        #1;
        check("raw_after_edge", full_1_data, 32'hA5A5A5A5);

        // Out-of-range writes on the small instance are ignored and reads return zero.
        set_write(1'b1, 5'd25, 32'hCAFEF00D);
        edge_commit();
        set_write(1'b0, 5'd0, 32'h0);
        register_1_read_addr_i = 5'd25;
        #1;
        check("oor_small", small_1_data, 32'h0);
        check("oor_full",  full_1_data,  32'hCAFEF00D);

        // Randomized traffic against the models.
        for (int k = 0; k < 300; k++) begin
            set_write(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
            if ($urandom_range(0, 3) == 0) ra1 = register_write_addr_i;
            else ra1 = 5'($urandom_range(0, 31));
            ra2 = 5'($urandom_range(0, 31));
            check_ports("rand_pre", ra1, ra2);
            edge_commit();
            check_ports("rand_post", ra1, ra2);
        end

        // Async reset between edges: outputs drop at once, writes under reset do nothing.
        set_write(1'b0, 5'd0, 32'h0);
        @(posedge clock_i);
        #2;
        register_1_read_addr_i = 5'd9;
        register_2_read_addr_i = 5'd15;
        #1;
        check("pre_async_p1", full_1_data, model_full[9]);
        reset_i = 1'b1;
        clear_models();
        set_write(1'b1, 5'd9, 32'h5555AAAA);
        #1;
        check("async_reset_p1", full_1_data, 32'h0);
        check("async_reset_p2", full_2_data, 32'h0);
        edge_commit();
        check_ports("reset_write", 5'd9, 5'd15);
        #2;
        reset_i = 1'b0;
        set_write(1'b0, 5'd0, 32'h0);
        #1;
        check("post_reset_r9", full_1_data, 32'h0);
        for (int a = 0; a < 32; a++) check_ports("post_reset_all", 5'(a), 5'(31 - a));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
